// File: rtl/wrr_gnt_xfer.sv
// Purpose : turns the WRR arbiter's one-hot grant into burst ownership of one output channel,
//           muxes the owner's beats into a 2-entry output buffer and locks the arbiter until the last beat.
// Latency : 1 cycle from beat accept to o_valid; 1 cycle from grant capture to first o_ready.
// Backpr. : o_ready[owner] drops while the buffer holds 2 beats; the buffer holds its head while i_ready=0.
// Ports   : clk/rst_n (async active-low); i_gnt/i_valid/i_data/i_last/o_ready per client;
//           o_lock back to the arbiter; o_valid/o_data/o_id/o_last/i_ready output channel; o_gnt_err sticky.
// Option  : `define WRR_GNT_XFER_BEAT_CNT_EN adds o_xfer_done / o_xfer_beats (per-burst beat count).
module wrr_gnt_xfer #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = $clog2(NUM_CLIENTS),
    parameter int CNT_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CLIENTS-1:0]            i_gnt,
    input  logic [NUM_CLIENTS-1:0]            i_valid,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_CLIENTS-1:0]            i_last,
    output logic [NUM_CLIENTS-1:0]            o_ready,
    output logic [NUM_CLIENTS-1:0]            o_lock,
    output logic                              o_valid,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic [ID_WIDTH-1:0]               o_id,
    output logic                              o_last,
    input  logic                              i_ready,
    output logic                              o_gnt_err
`ifdef WRR_GNT_XFER_BEAT_CNT_EN
    ,
    output logic                              o_xfer_done,
    output logic [CNT_WIDTH-1:0]              o_xfer_beats
`endif
);

    if (NUM_CLIENTS < 2 || CNT_WIDTH < 1) begin : g_param_chk
        $error("wrr_gnt_xfer: NUM_CLIENTS must be >= 2 and CNT_WIDTH >= 1");
    end

    typedef enum logic {ST_IDLE, ST_XFER} state_e;

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     owner_q, owner_d;
    logic [NUM_CLIENTS-1:0]  lock_q, lock_d;
    logic                    gnt_err_q, gnt_err_d;

    // Output buffer: 2 entries, pointer-addressed so the head never moves while stalled.
    logic [DATA_WIDTH-1:0]   buf_dat_q [2];
    logic [ID_WIDTH-1:0]     buf_id_q  [2];
    logic [1:0]              buf_last_q;
    logic                    rd_ptr_q, wr_ptr_q;
    logic [1:0]              cnt_q, cnt_d;

    logic                    gnt_multi, gnt_onehot, capture;
    logic [ID_WIDTH-1:0]     gnt_idx;
    logic                    own_vld, own_last;
    logic [DATA_WIDTH-1:0]   own_dat;
    logic                    can_push, accept, pop;

    // x & (x-1) clears the lowest set bit; anything left means two or more grants.
    assign gnt_multi  = (i_gnt & (i_gnt - {{(NUM_CLIENTS-1){1'b0}}, 1'b1})) != '0;
    assign gnt_onehot = (i_gnt != '0) && !gnt_multi;
    assign capture    = (state_q == ST_IDLE) && gnt_onehot && ((i_gnt & i_valid) != '0);

    always_comb begin
        gnt_idx  = '0;
        own_vld  = 1'b0;
        own_last = 1'b0;
        own_dat  = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (i_gnt[k]) begin
                gnt_idx = ID_WIDTH'(k);
            end
            if (owner_q == ID_WIDTH'(k)) begin
                own_vld  = i_valid[k];
                own_last = i_last[k];
                own_dat  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign can_push = (cnt_q != 2'd2);
    assign accept   = (state_q == ST_XFER) && own_vld && can_push;
    assign pop      = o_valid && i_ready;

    always_comb begin
        o_ready = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            o_ready[k] = (state_q == ST_XFER) && (owner_q == ID_WIDTH'(k)) && can_push;
        end
    end

    // Grant is only looked at in IDLE; an open burst ignores it completely.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lock_d    = lock_q;
        gnt_err_d = gnt_err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_multi) begin
                    gnt_err_d = 1'b1;
                end else if (capture) begin
                    state_d = ST_XFER;
                    owner_d = gnt_idx;
                    lock_d  = i_gnt;
                end
            end
            ST_XFER: begin
                if (accept && own_last) begin
                    state_d = ST_IDLE;
                    lock_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!accept && pop) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            lock_q     <= '0;
            gnt_err_q  <= 1'b0;
            cnt_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_last_q <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_dat_q[i] <= '0;
                buf_id_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lock_q    <= lock_d;
            gnt_err_q <= gnt_err_d;
            cnt_q     <= cnt_d;
            if (accept) begin
                buf_dat_q[wr_ptr_q]  <= own_dat;
                buf_id_q[wr_ptr_q]   <= owner_q;
                buf_last_q[wr_ptr_q] <= own_last;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign o_lock    = lock_q;
    assign o_gnt_err = gnt_err_q;
    assign o_valid   = (cnt_q != 2'd0);
    assign o_data    = buf_dat_q[rd_ptr_q];
    assign o_id      = buf_id_q[rd_ptr_q];
    assign o_last    = buf_last_q[rd_ptr_q];

`ifdef WRR_GNT_XFER_BEAT_CNT_EN
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] beats_q, beats_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] beat_inc;

    // Saturating increment so a very long burst reports the maximum count.
    assign beat_inc = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + CNT_WIDTH'(1);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        beats_d    = beats_q;
        done_d     = 1'b0;
        if (capture) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_inc;
            if (own_last) begin
                beats_d = beat_inc;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            beats_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            beats_q    <= beats_d;
            done_q     <= done_d;
        end
    end

    assign o_xfer_done  = done_q;
    assign o_xfer_beats = beats_q;
`endif

endmodule

// File: tb/tb_wrr_gnt_xfer.sv
// Purpose : self-checking bench for wrr_gnt_xfer: directed scenarios plus randomized traffic
//           compared every cycle against a queue-based behavioural model.
// Latency : n/a (bench). Backpressure : i_ready driven both directed and randomly.
module tb_wrr_gnt_xfer;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    i_gnt = '0;
    logic [N-1:0]    i_valid = '0;
    logic [N*DW-1:0] i_data = '0;
    logic [N-1:0]    i_last = '0;
    logic            i_ready = 1'b1;
    logic [N-1:0]    o_ready, o_lock;
    logic            o_valid, o_last, o_gnt_err;
    logic [DW-1:0]   o_data;
    logic [IW-1:0]   o_id;
`ifdef WRR_GNT_XFER_BEAT_CNT_EN
    logic            o_xfer_done;
    logic [CW-1:0]   o_xfer_beats;
`endif

    wrr_gnt_xfer #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_gnt(i_gnt), .i_valid(i_valid), .i_data(i_data),
        .i_last(i_last), .o_ready(o_ready), .o_lock(o_lock), .o_valid(o_valid),
        .o_data(o_data), .o_id(o_id), .o_last(o_last), .i_ready(i_ready),
        .o_gnt_err(o_gnt_err)
`ifdef WRR_GNT_XFER_BEAT_CNT_EN
        , .o_xfer_done(o_xfer_done), .o_xfer_beats(o_xfer_beats)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        logic          l;
    } beat_t;

    beat_t        mq[$];
    bit           m_xfer;
    int           m_owner;
    bit           m_err;
    bit           m_done;
    int           m_cnt;
    int           m_beats;
    logic [N-1:0] exp_rdy, exp_lock;
    bit           m_acc, m_pop;
    int           m_g;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_xfer = 0; m_owner = 0; m_err = 0; m_done = 0; m_cnt = 0; m_beats = 0;
            chk("rst_valid", o_valid, 0);
            chk("rst_lock", o_lock, 0);
            chk("rst_ready", o_ready, 0);
            chk("rst_err", o_gnt_err, 0);
            chk("rst_data", o_data, 0);
            chk("rst_id", o_id, 0);
            chk("rst_last", o_last, 0);
`ifdef WRR_GNT_XFER_BEAT_CNT_EN
            chk("rst_done", o_xfer_done, 0);
            chk("rst_beats", o_xfer_beats, 0);
`endif
        end else begin
            exp_rdy = '0;
            exp_lock = '0;
            if (m_xfer && mq.size() < 2) exp_rdy[m_owner] = 1'b1;
            if (m_xfer) exp_lock[m_owner] = 1'b1;
            chk("ready", o_ready, exp_rdy);
            chk("lock", o_lock, exp_lock);
            chk("gnt_err", o_gnt_err, m_err);
            chk("valid", o_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("data", o_data, mq[0].d);
                chk("id", o_id, mq[0].id);
                chk("last", o_last, mq[0].l);
            end
`ifdef WRR_GNT_XFER_BEAT_CNT_EN
            chk("xfer_done", o_xfer_done, m_done);
            chk("xfer_beats", o_xfer_beats, m_beats);
`endif
            // advance the model across the coming rising edge
            m_acc = m_xfer && i_valid[m_owner] && (mq.size() < 2);
            m_pop = (mq.size() != 0) && i_ready;
            m_done = 0;
            if (m_pop) void'(mq.pop_front());
            if (m_acc) begin
                mq.push_back('{d: i_data[m_owner*DW +: DW], id: IW'(m_owner), l: i_last[m_owner]});
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                if (i_last[m_owner]) begin
                    m_xfer = 0;
                    m_done = 1;
                    m_beats = m_cnt;
                end
            end else if (!m_xfer) begin
                if ($countones(i_gnt) == 1) begin
                    m_g = 0;
                    for (int k = 0; k < N; k++) if (i_gnt[k]) m_g = k;
                    if (i_valid[m_g]) begin
                        m_xfer = 1;
                        m_owner = m_g;
                        m_cnt = 0;
                    end
                end else if ($countones(i_gnt) > 1) begin
                    m_err = 1;
                end
            end
        end
    end

    // ---------------- observation of delivered beats ----------------
    logic [DW-1:0] obs_d[$];
    logic [IW-1:0] obs_i[$];
    logic          obs_l[$];
    int            obs_c[$];
    int            cyc = 0;
    logic [N-1:0]  watch_lock = '0;
    int            lock_cnt = 0;
    int            done_cnt = 0;
    int            last_beats = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (o_valid && i_ready) begin
                obs_d.push_back(o_data);
                obs_i.push_back(o_id);
                obs_l.push_back(o_last);
                obs_c.push_back(cyc);
            end
            if (o_lock == watch_lock) lock_cnt++;
`ifdef WRR_GNT_XFER_BEAT_CNT_EN
            if (o_xfer_done) begin
                done_cnt++;
                last_beats = int'(o_xfer_beats);
            end
`endif
        end
    end

    task automatic obs_clear();
        obs_d.delete(); obs_i.delete(); obs_l.delete(); obs_c.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_obs(input string nm, input int idx, input logic [DW-1:0] d,
                           input logic [IW-1:0] id, input logic l);
        if (idx < obs_d.size()) begin
            chk({nm, "_data"}, obs_d[idx], d);
            chk({nm, "_id"}, obs_i[idx], id);
            chk({nm, "_last"}, obs_l[idx], l);
        end
    endtask

    // Drives one burst of n beats from client c; called at posedge+1.
    task automatic send_burst(input int c, input int n, input logic [DW-1:0] base);
        logic [N-1:0] oh;
        int sent, to;
        bit acc;
        oh = '0;
        oh[c] = 1'b1;
        i_gnt = oh;
        i_valid[c] = 1'b1;
        i_data[c*DW +: DW] = base;
        i_last[c] = (n == 1);
        sent = 0;
        to = 0;
        while (sent < n && to < 200) begin
            @(negedge clk);
            acc = o_ready[c] && i_valid[c];
            step();
            if (acc) begin
                sent++;
                if (sent < n) begin
                    i_data[c*DW +: DW] = base + DW'(sent);
                    i_last[c] = (sent == n - 1);
                end
            end
            to++;
        end
        chk("burst_timeout", to >= 200, 0);
        i_valid[c] = 1'b0;
        i_last[c] = 1'b0;
        if (i_gnt == oh) i_gnt = '0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // 1: three-beat burst from client 1, no backpressure
        obs_clear();
        watch_lock = 4'b0010;
        lock_cnt = 0;
        send_burst(1, 3, 32'hA0);
        repeat (6) step();
        chk("t1_nbeats", obs_d.size(), 3);
        for (int i = 0; i < 3; i++) chk_obs("t1", i, 32'hA0 + i, 2'd1, i == 2);
        if (obs_c.size() == 3) chk("t1_consec", obs_c[2] - obs_c[0], 2);
        chk("t1_lock_cycles", lock_cnt, 3);

        // 2: same burst with the output stalled for 4 cycles
        obs_clear();
        fork
            send_burst(1, 3, 32'hA0);
            begin
                i_ready = 1'b0;
                repeat (3) step();
                @(negedge clk);
                chk("t2_hold_data", o_data, 32'hA0);
                chk("t2_ready_full", o_ready, 4'b0000);
                step();
                i_ready = 1'b1;
            end
        join
        repeat (6) step();
        chk("t2_nbeats", obs_d.size(), 3);
        for (int i = 0; i < 3; i++) chk_obs("t2", i, 32'hA0 + i, 2'd1, i == 2);

        // 3: grant moves to client 0 in the middle of client 2's burst
        obs_clear();
        fork
            send_burst(2, 4, 32'hB0);
            begin
                repeat (3) step();
                i_gnt = 4'b0001;
                i_valid[0] = 1'b1;
                i_data[0 +: DW] = 32'hC0;
                i_last[0] = 1'b1;
            end
        join
        send_burst(0, 1, 32'hC0);
        repeat (6) step();
        chk("t3_nbeats", obs_d.size(), 5);
        for (int i = 0; i < 4; i++) chk_obs("t3", i, 32'hB0 + i, 2'd2, i == 3);
        chk_obs("t3", 4, 32'hC0, 2'd0, 1'b1);
        chk("t3_no_err", o_gnt_err, 0);

        // 4: illegal grant in IDLE, then a legal one
        i_gnt = 4'b0110;
        i_valid = 4'b0110;
        step();
        i_gnt = '0;
        i_valid = '0;
        @(negedge clk);
        chk("t4_err_set", o_gnt_err, 1);
        chk("t4_no_capture", o_lock, 4'b0000);
        step();
        obs_clear();
        send_burst(2, 2, 32'hE0);
        repeat (6) step();
        chk("t4_nbeats", obs_d.size(), 2);
        chk_obs("t4", 0, 32'hE0, 2'd2, 1'b0);
        chk_obs("t4", 1, 32'hE1, 2'd2, 1'b1);
        chk("t4_err_sticky", o_gnt_err, 1);

        // 5: back-to-back single-beat bursts, clients 3 then 0
        obs_clear();
        send_burst(3, 1, 32'hD3);
        send_burst(0, 1, 32'hD0);
        repeat (6) step();
        chk("t5_nbeats", obs_d.size(), 2);
        chk_obs("t5a", 0, 32'hD3, 2'd3, 1'b1);
        chk_obs("t5b", 1, 32'hD0, 2'd0, 1'b1);

        // 6: asynchronous reset with two beats buffered
        i_ready = 1'b0;
        i_gnt = 4'b0010;
        i_valid[1] = 1'b1;
        i_data[DW +: DW] = 32'h55;
        i_last[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("t6_full_before", o_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", o_valid, 0);
        chk("t6_async_lock", o_lock, 4'b0000);
        chk("t6_async_err", o_gnt_err, 0);
        i_gnt = '0;
        i_valid = '0;
        i_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // 5-beat burst: beat count / done pulse
        obs_clear();
        done_cnt = 0;
        last_beats = 0;
        send_burst(1, 5, 32'hF0);
        repeat (6) step();
        chk("t6_nbeats", obs_d.size(), 5);
        chk_obs("t6", 4, 32'hF4, 2'd1, 1'b1);
`ifdef WRR_GNT_XFER_BEAT_CNT_EN
        chk("t6_done_pulses", done_cnt, 1);
        chk("t6_beats", last_beats, 5);
`endif

        // randomized traffic; illegal grants only late so both err states get exercised
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70)
                i_gnt = 4'b0001 << $urandom_range(0, N - 1);
            else if (r < 98 || c < 2000)
                i_gnt = '0;
            else
                i_gnt = 4'($urandom_range(0, 15));
            i_valid = 4'($urandom | $urandom);
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            i_last  = 4'($urandom & $urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        i_valid = '0;
        i_gnt = '0;
        i_ready = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
